// File: rtl/simd_pkg.sv
// -----------------------------------------------------------------------------
// simd_pkg
// Definitions shared by the instruction fetch unit and its neighbours.
//   INSTR_WIDTH   : width of one instruction word handed to the decoder
//   opcode_t      : 4-bit opcode carried in instr[3:0]
//   fetch_state_t : state encoding of the fetch sequencer
// -----------------------------------------------------------------------------
package simd_pkg;

    localparam int INSTR_WIDTH = 12;

    typedef enum logic [3:0] {
        OP_START = 4'h0,
        OP_LOAD  = 4'h1,
        OP_STORE = 4'h2,
        OP_ADD   = 4'h3,
        OP_MUL   = 4'h4,
        OP_NOP   = 4'h7,
        OP_STOP  = 4'h8
    } opcode_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_PRESENT,
        S_HALT
    } fetch_state_t;

endpackage

// File: rtl/instr_fetch_if.sv
// -----------------------------------------------------------------------------
// instr_fetch_if
// Bundles the instruction-memory read port and the decoder handshake.
//   mem_addr    : instruction-memory address (fetch unit -> memory)
//   mem_re      : instruction-memory read enable (fetch unit -> memory)
//   mem_data    : read data, valid one cycle after mem_re (memory -> fetch unit)
//   instr       : fetched instruction (fetch unit -> decoder)
//   instr_valid : instr holds a valid instruction (fetch unit -> decoder)
//   instr_ready : decoder accepts instr (decoder -> fetch unit)
// Modports: master = fetch unit side, slave = memory/decoder side.
// -----------------------------------------------------------------------------
interface instr_fetch_if #(
    parameter int DATA_WIDTH  = 128,
    parameter int AW          = 8,
    parameter int INSTR_WIDTH = simd_pkg::INSTR_WIDTH
) ();

    logic [AW-1:0]          mem_addr;
    logic                   mem_re;
    logic [DATA_WIDTH-1:0]  mem_data;
    logic [INSTR_WIDTH-1:0] instr;
    logic                   instr_valid;
    logic                   instr_ready;

    modport master (
        output mem_addr,
        output mem_re,
        input  mem_data,
        output instr,
        output instr_valid,
        input  instr_ready
    );

    modport slave (
        input  mem_addr,
        input  mem_re,
        output mem_data,
        input  instr,
        input  instr_valid,
        output instr_ready
    );

endinterface

// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
// Sequential instruction fetch unit. On start it reads instructions from
// address 0 upwards, one at a time, presenting each to the decoder until it is
// accepted. Execution ends on OP_STOP, or with wrap_err when the program runs
// off the end of memory.
// Ports:
//   clk      : clock, rising edge
//   rst      : synchronous active-high reset
//   start    : begin execution at address 0 (honoured in IDLE/HALT only)
//   bus      : memory read port + decoder handshake (instr_fetch_if.master)
//   pc       : address of current / last fetched instruction
//   busy     : high in FETCH, WAIT and PRESENT
//   done     : high in HALT
//   wrap_err : sticky, program ran past DEPTH-1 without STOP
// -----------------------------------------------------------------------------
module instr_fetch #(
    parameter int  DATA_WIDTH  = 128,
    parameter int  DEPTH       = 256,
    parameter int  INSTR_WIDTH = simd_pkg::INSTR_WIDTH,
    localparam int AW          = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    instr_fetch_if.master    bus,
    output logic [AW-1:0]    pc,
    output logic             busy,
    output logic             done,
    output logic             wrap_err
);

    import simd_pkg::*;

    localparam logic [AW-1:0] PC_LAST = AW'(DEPTH - 1);

    fetch_state_t           r_state;
    fetch_state_t           w_state_next;
    logic [AW-1:0]          r_pc;
    logic [AW-1:0]          w_pc_next;
    logic [INSTR_WIDTH-1:0] r_instr;
    logic [INSTR_WIDTH-1:0] w_instr_next;
    logic                   r_wrap_err;
    logic                   w_wrap_err_next;
    logic                   w_is_stop;

    assign w_is_stop = (r_instr[3:0] == OP_STOP);

    // Only the low INSTR_WIDTH bits of the memory word carry the instruction.
    generate
        if (DATA_WIDTH > INSTR_WIDTH) begin : g_unused_bits
            logic w_unused_mem_bits;
            assign w_unused_mem_bits = ^bus.mem_data[DATA_WIDTH-1:INSTR_WIDTH];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_pc       <= '0;
            r_instr    <= '0;
            r_wrap_err <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_pc       <= w_pc_next;
            r_instr    <= w_instr_next;
            r_wrap_err <= w_wrap_err_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_pc_next       = r_pc;
        w_instr_next    = r_instr;
        w_wrap_err_next = r_wrap_err;

        case (r_state)
            S_IDLE, S_HALT: begin
                if (start) begin
                    w_pc_next       = '0;
                    w_wrap_err_next = 1'b0;
                    w_state_next    = S_FETCH;
                end
            end

            // Read is issued this cycle; the memory answers one cycle later.
            S_FETCH: begin
                w_state_next = S_WAIT;
            end

            S_WAIT: begin
                w_instr_next = bus.mem_data[INSTR_WIDTH-1:0];
                w_state_next = S_PRESENT;
            end

            S_PRESENT: begin
                if (bus.instr_ready) begin
                    if (w_is_stop) begin
                        w_state_next = S_HALT;
                    end else if (r_pc == PC_LAST) begin
                        // Out of memory without STOP: halt, never wrap pc.
                        w_wrap_err_next = 1'b1;
                        w_state_next    = S_HALT;
                    end else begin
                        w_pc_next    = r_pc + AW'(1);
                        w_state_next = S_FETCH;
                    end
                end
            end

            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    assign bus.mem_addr    = r_pc;
    assign bus.mem_re      = (r_state == S_FETCH);
    assign bus.instr       = r_instr;
    assign bus.instr_valid = (r_state == S_PRESENT);

    assign pc       = r_pc;
    assign busy     = (r_state == S_FETCH) || (r_state == S_WAIT) || (r_state == S_PRESENT);
    assign done     = (r_state == S_HALT);
    assign wrap_err = r_wrap_err;

endmodule

// File: tb/tb_instr_fetch.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch
// Directed testbench for instr_fetch with a registered-read instruction memory
// model. Each scenario task drives its own stimulus and checks its own results.
// -----------------------------------------------------------------------------
module tb_instr_fetch;

    localparam int DW    = 128;
    localparam int DEPTH = 256;
    localparam int IW    = 12;
    localparam int AW    = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] pc;
    logic          busy;
    logic          done;
    logic          wrap_err;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] mem [DEPTH];

    instr_fetch_if #(.DATA_WIDTH(DW), .AW(AW), .INSTR_WIDTH(IW)) bus ();

    instr_fetch #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .INSTR_WIDTH(IW)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .bus      (bus.master),
        .pc       (pc),
        .busy     (busy),
        .done     (done),
        .wrap_err (wrap_err)
    );

    always #5 clk = ~clk;

    // Registered-read memory model
    always @(posedge clk) begin
        if (bus.mem_re) bus.mem_data <= mem[bus.mem_addr];
    end

    // ---------------------------------------------------------------- helpers
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Upper bits set to ones so that only the low IW bits may reach instr.
    task automatic load_word(input int a, input logic [IW-1:0] v);
        mem[a] = {{(DW-IW){1'b1}}, v};
    endtask

    task automatic fill_stop();
        for (int i = 0; i < DEPTH; i++) load_word(i, 12'h008);
    endtask

    // Called #1 after an edge; returns #1 after edge k (start sampled at k).
    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_valid(input int budget, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            if (bus.instr_valid) begin
                ok = 1'b1;
                return;
            end
            tick();
        end
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            if (done) begin
                ok = 1'b1;
                return;
            end
            tick();
        end
    endtask

    function automatic logic [IW-1:0] wrap_word(input int i);
        return IW'((i << 4) | (i % 8));
    endfunction

    // ---------------------------------------------------------------- tests
    task automatic test_reset();
        rst = 1'b1;
        start = 1'b1;
        bus.instr_ready = 1'b1;
        tick();
        tick();
        checks++;
        if ({busy, done, wrap_err, bus.mem_re, bus.instr_valid} !== 5'b00000) begin
            errors++;
            $display("FAIL reset_flags: busy/done/wrap/re/valid got %b expected 00000",
                     {busy, done, wrap_err, bus.mem_re, bus.instr_valid});
        end
        checks++;
        if (pc !== 8'd0) begin
            errors++;
            $display("FAIL reset_pc: got %0d expected 0", pc);
        end
        checks++;
        if (bus.instr !== 12'h000) begin
            errors++;
            $display("FAIL reset_instr: got %h expected 000", bus.instr);
        end
        rst = 1'b0;
        start = 1'b0;
        tick();
        checks++;
        if ({busy, done, bus.mem_re} !== 3'b000) begin
            errors++;
            $display("FAIL reset_idle: busy/done/re got %b expected 000", {busy, done, bus.mem_re});
        end
        $display("test_reset complete");
    endtask

    task automatic test_program();
        logic [IW-1:0] exp_q [3];
        logic [IW-1:0] got_q [$];
        exp_q[0] = 12'h000;
        exp_q[1] = 12'h009;
        exp_q[2] = 12'h008;
        fill_stop();
        for (int i = 0; i < 3; i++) load_word(i, exp_q[i]);
        bus.instr_ready = 1'b1;
        pulse_start();
        checks++;
        if ({bus.mem_re, bus.mem_addr, bus.instr_valid, busy} !== {1'b1, 8'd0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL latency_fetch: re/addr/valid/busy got %b/%0d/%b/%b expected 1/0/0/1",
                     bus.mem_re, bus.mem_addr, bus.instr_valid, busy);
        end
        tick();
        checks++;
        if ({bus.mem_re, bus.instr_valid, busy} !== 3'b001) begin
            errors++;
            $display("FAIL latency_wait: re/valid/busy got %b expected 001",
                     {bus.mem_re, bus.instr_valid, busy});
        end
        tick();
        checks++;
        if ({bus.instr_valid, bus.instr} !== {1'b1, 12'h000}) begin
            errors++;
            $display("FAIL latency_present: valid/instr got %b/%h expected 1/000",
                     bus.instr_valid, bus.instr);
        end
        for (int c = 0; c < 60; c++) begin
            if (done) break;
            if (bus.instr_valid) got_q.push_back(bus.instr);
            tick();
        end
        checks++;
        if (got_q.size() != 3) begin
            errors++;
            $display("FAIL program_count: got %0d instructions expected 3", got_q.size());
        end
        for (int i = 0; i < 3 && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL program_instr%0d: got %h expected %h", i, got_q[i], exp_q[i]);
            end
        end
        checks++;
        if ({done, wrap_err, busy, bus.instr_valid, pc} !== {4'b1000, 8'd2}) begin
            errors++;
            $display("FAIL program_end: done/wrap/busy/valid got %b pc %0d expected 1000 pc 2",
                     {done, wrap_err, busy, bus.instr_valid}, pc);
        end
        $display("test_program complete");
    endtask

    task automatic test_stall();
        bit ok;
        fill_stop();
        load_word(0, 12'h001);
        load_word(1, 12'h009);
        load_word(2, 12'h008);
        bus.instr_ready = 1'b0;
        pulse_start();
        wait_valid(10, ok);
        checks++;
        if (!ok || bus.instr !== 12'h001) begin
            errors++;
            $display("FAIL stall_first: valid %b instr %h expected 1 001", ok, bus.instr);
        end
        bus.instr_ready = 1'b1;
        tick();
        bus.instr_ready = 1'b0;
        wait_valid(10, ok);
        checks++;
        if (!ok || bus.instr !== 12'h009 || pc !== 8'd1) begin
            errors++;
            $display("FAIL stall_second: valid %b instr %h pc %0d expected 1 009 1", ok, bus.instr, pc);
        end
        for (int c = 0; c < 5; c++) begin
            checks++;
            if ({bus.instr, pc, bus.mem_re, bus.instr_valid} !== {12'h009, 8'd1, 1'b0, 1'b1}) begin
                errors++;
                $display("FAIL stall_hold%0d: instr %h pc %0d re %b valid %b expected 009 1 0 1",
                         c, bus.instr, pc, bus.mem_re, bus.instr_valid);
            end
            tick();
        end
        bus.instr_ready = 1'b1;
        tick();
        checks++;
        if ({bus.mem_re, bus.mem_addr, bus.instr_valid} !== {1'b1, 8'd2, 1'b0}) begin
            errors++;
            $display("FAIL stall_release: re/addr/valid got %b/%0d/%b expected 1/2/0",
                     bus.mem_re, bus.mem_addr, bus.instr_valid);
        end
        wait_done(20, ok);
        checks++;
        if (!ok || pc !== 8'd2 || wrap_err !== 1'b0) begin
            errors++;
            $display("FAIL stall_done: done %b pc %0d wrap %b expected 1 2 0", ok, pc, wrap_err);
        end
        $display("test_stall complete");
    endtask

    task automatic test_wrap();
        int n;
        int reads;
        n = 0;
        for (int i = 0; i < DEPTH; i++) load_word(i, wrap_word(i));
        bus.instr_ready = 1'b1;
        pulse_start();
        for (int c = 0; c < 1000; c++) begin
            if (done) break;
            if (bus.instr_valid) begin
                if (n < DEPTH) begin
                    checks++;
                    if (bus.instr !== wrap_word(n)) begin
                        errors++;
                        $display("FAIL wrap_instr%0d: got %h expected %h", n, bus.instr, wrap_word(n));
                    end
                end
                n++;
            end
            tick();
        end
        checks++;
        if (n != DEPTH) begin
            errors++;
            $display("FAIL wrap_count: got %0d handshakes expected %0d", n, DEPTH);
        end
        checks++;
        if ({done, wrap_err, busy, pc} !== {3'b110, 8'd255}) begin
            errors++;
            $display("FAIL wrap_end: done/wrap/busy got %b pc %0d expected 110 pc 255",
                     {done, wrap_err, busy}, pc);
        end
        reads = 0;
        for (int c = 0; c < 10; c++) begin
            if (bus.mem_re) reads++;
            tick();
        end
        checks++;
        if (reads != 0 || wrap_err !== 1'b1 || done !== 1'b1) begin
            errors++;
            $display("FAIL wrap_halt: reads %0d wrap %b done %b expected 0 1 1", reads, wrap_err, done);
        end
        $display("test_wrap complete");
    endtask

    task automatic test_start_ignored();
        bit ok;
        fill_stop();
        load_word(0, 12'h001);
        load_word(1, 12'h008);
        bus.instr_ready = 1'b0;
        pulse_start();
        checks++;
        if ({wrap_err, done, bus.mem_re} !== 3'b001) begin
            errors++;
            $display("FAIL restart_clear: wrap/done/re got %b expected 001", {wrap_err, done, bus.mem_re});
        end
        wait_valid(10, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL ignore_valid: got valid 0 expected 1");
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 2; c++) begin
            checks++;
            if ({pc, bus.instr, bus.instr_valid, bus.mem_re} !== {8'd0, 12'h001, 1'b1, 1'b0}) begin
                errors++;
                $display("FAIL ignore_start%0d: pc %0d instr %h valid %b re %b expected 0 001 1 0",
                         c, pc, bus.instr, bus.instr_valid, bus.mem_re);
            end
            tick();
        end
        bus.instr_ready = 1'b1;
        wait_done(20, ok);
        checks++;
        if (!ok || pc !== 8'd1) begin
            errors++;
            $display("FAIL ignore_done: done %b pc %0d expected 1 1", ok, pc);
        end
        $display("test_start_ignored complete");
    endtask

    task automatic test_reset_in_wait();
        bit ok;
        ok = 1'b0;
        fill_stop();
        load_word(0, 12'h001);
        load_word(1, 12'h123);
        load_word(2, 12'h008);
        bus.instr_ready = 1'b1;
        pulse_start();
        for (int c = 0; c < 20; c++) begin
            if (pc == 8'd1 && busy && !bus.mem_re && !bus.instr_valid) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL rstwait_reach: got WAIT at pc 1 = 0 expected 1");
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({bus.instr_valid, busy, done, pc, bus.instr} !== {3'b000, 8'd0, 12'h000}) begin
            errors++;
            $display("FAIL rstwait_state: valid/busy/done %b pc %0d instr %h expected 000 0 000",
                     {bus.instr_valid, busy, done}, pc, bus.instr);
        end
        tick();
        checks++;
        if ({bus.instr_valid, busy, bus.mem_re, bus.instr} !== {3'b000, 12'h000}) begin
            errors++;
            $display("FAIL rstwait_discard: valid/busy/re %b instr %h expected 000 000",
                     {bus.instr_valid, busy, bus.mem_re}, bus.instr);
        end
        pulse_start();
        checks++;
        if ({bus.mem_re, bus.mem_addr} !== {1'b1, 8'd0}) begin
            errors++;
            $display("FAIL rstwait_restart: re/addr got %b/%0d expected 1/0", bus.mem_re, bus.mem_addr);
        end
        bus.instr_ready = 1'b0;
        wait_valid(10, ok);
        checks++;
        if (!ok || bus.instr !== 12'h001) begin
            errors++;
            $display("FAIL rstwait_instr: valid %b instr %h expected 1 001", ok, bus.instr);
        end
        $display("test_reset_in_wait complete");
    endtask

    // ---------------------------------------------------------------- main
    initial begin
        bus.instr_ready = 1'b0;
        test_reset();
        test_program();
        test_stall();
        test_wrap();
        test_start_ignored();
        test_reset_in_wait();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter DATA_WIDTH, default 128: width of the instruction-memory read port.
REQ-002 Parameter DEPTH, default 256: instruction-memory word count; AW = $clog2(DEPTH).
REQ-003 Parameter INSTR_WIDTH, default 12: instruction width, taken from mem_data[INSTR_WIDTH-1:0].
REQ-004 One clock; reset is synchronous and active-high; clock port clk, reset port rst.
REQ-005 clk  in  1  clock, all state updates on its rising edge.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 start  in  1  begin program execution at address 0.
REQ-008 mem_addr  out  AW  instruction-memory address; equals pc.
REQ-009 mem_re  out  1  instruction-memory read enable.
REQ-010 mem_data  in  DATA_WIDTH  instruction-memory read data, valid one cycle after mem_re.
REQ-011 instr  out  INSTR_WIDTH  fetched instruction to the decoder.
REQ-012 instr_valid  out  1  instr holds a valid instruction.
REQ-013 instr_ready  in  1  decoder accepts instr.
REQ-014 pc  out  AW  address of the current or last fetched instruction.
REQ-015 busy  out  1  high in FETCH, WAIT and PRESENT.
REQ-016 done  out  1  program finished; high in HALT.
REQ-017 wrap_err  out  1  program ran past DEPTH-1 without STOP; sticky until start or rst.

Function
REQ-018 FSM states: IDLE, FETCH, WAIT, PRESENT, HALT.
REQ-019 IDLE or HALT, start=1: pc<=0, done<=0, wrap_err<=0, next state FETCH.
REQ-020 start is ignored in FETCH, WAIT and PRESENT.
REQ-021 FETCH: mem_re=1 (combinational decode of state), mem_addr=pc, next state WAIT unconditionally.
REQ-022 mem_re=0 in every state other than FETCH; the block never drives a write.
REQ-023 WAIT: instr<=mem_data[INSTR_WIDTH-1:0], next state PRESENT.
REQ-024 Latency: start sampled at edge k gives mem_re in cycle k+1 and instr_valid in cycle k+3.
REQ-025 PRESENT: instr_valid=1; while instr_ready=0, instr, pc and state hold and mem_re stays 0.
REQ-026 PRESENT, instr_ready=1, instr[3:0]==OP_STOP (4'h8): next state HALT, pc unchanged.
REQ-027 PRESENT, instr_ready=1, not STOP, pc<DEPTH-1: pc<=pc+1, next state FETCH.
REQ-028 PRESENT, instr_ready=1, not STOP, pc==DEPTH-1: wrap_err<=1, next state HALT, pc not wrapped.
REQ-029 Steady-state throughput: one instruction per 3 cycles with instr_ready held high.
REQ-030 All opcodes other than STOP, including OP_START (4'h0), pass through unmodified.
REQ-031 HALT: done=1, instr_valid=0, busy=0; stays in HALT until start or rst.

Reset
REQ-032 rst=1 at an edge forces: state IDLE, pc=0, instr=0, instr_valid=0, mem_re=0, busy=0, done=0, wrap_err=0.
REQ-033 rst overrides start and instr_ready in the same cycle, and aborts any in-flight fetch; the returning mem_data is discarded.

Structure
REQ-034 Shared package simd_pkg holds INSTR_WIDTH, the 4-bit opcode enum (OP_START=0, OP_STOP=8, …) and the fetch_state_t enum.
REQ-035 No sub-module; the memory is instantiated by the parent and connects via mem_addr, mem_re and mem_data.

Verification
REQ-036 mem[0..2]=0x000,0x009,0x008; pulse start; ready=1 -> instr 0x000, 0x009, 0x008 in order; then done=1, pc=2, wrap_err=0.
REQ-037 start sampled at edge 0 -> mem_re=1 with mem_addr=0 in cycle 1; instr_valid=1 in cycle 3.
REQ-038 ready=0 for 5 cycles during PRESENT (instr=0x009) -> instr stable, pc stable, mem_re=0 throughout; advances one cycle after ready=1.
REQ-039 No STOP in any of 256 words -> after 256 handshakes wrap_err=1, done=1, pc=255, no further mem_re.
REQ-040 rst asserted in WAIT -> next cycle instr_valid=0, pc=0, busy=0; a later start fetches address 0.
REQ-041 start pulsed during PRESENT -> ignored: pc and instr unchanged, no extra mem_re.
